id_issue_queue: RTL
===================

Name: id_issue_queue

Overview:
- Parametrised successor to the fixed ID/EXE latch.
- Sits between decode and EXE as a DEPTH-entry valid/ready queue carrying a generic DATA_W-bit decoded-instruction payload.
- Adds pipeline flush, a long-latency-op interlock (generalised DIV hold) and occupancy/issue statistics, none of which the single-register stall/bubble scheme provides.

Parameters:
- DATA_W, 192, payload width in bits (control plus operands plus PC).
- DEPTH, 2, queue entries; power of two, at least 2.
- CNT_W, 32, width of the issue statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  queue can accept; registered, no combinational path from out_ready.
- in_data  input  DATA_W  decoded payload.
- in_long  input  1  payload is a long-latency op (DIV class).
- out_valid  output  1  head entry is issuable to EXE.
- out_ready  input  1  EXE accepts the head.
- out_data  output  DATA_W  head payload.
- long_done  input  1  one-cycle pulse: long-latency unit finished.
- flush  input  1  discard all queued and incoming entries (branch or exception).
- occupancy  output  log2(DEPTH)+1  current entry count.
- long_busy  output  1  state is LONG_WAIT.
- issue_cnt  output  CNT_W  total entries popped, modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, immediate): count 0, wr_ptr and rd_ptr 0, storage cleared to 0, state IDLE, issue_cnt 0.
  - Resulting outputs: out_valid 0, out_data 0, in_ready 1 once rst is released (0 while rst is asserted), occupancy 0, long_busy 0.
- Push when in_valid & in_ready & ~flush:
  - Write {in_long, in_data} at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop when out_valid & out_ready:
  - rd_ptr increments modulo DEPTH.
  - issue_cnt increments, wrapping silently.
- out_valid = (count != 0) & (state == IDLE).
- out_data = payload at rd_ptr, forced to 0 when count == 0. This gives EXE a bubble, matching the legacy "zero control word" bubble.
- in_ready = registered (next_count != DEPTH).
- Count update on simultaneous push and pop: count unchanged, both pointers advance. Push only: +1. Pop only: -1.
- Full (count == DEPTH): in_ready 0; in_valid is ignored and the upstream stalls.
- Empty: a push becomes visible at out_valid the next cycle. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Long-op state machine:
  - IDLE -> LONG_WAIT when the popped head has the long flag set.
  - LONG_WAIT -> IDLE on long_done. The following entry is issuable the cycle after long_done.
  - While in LONG_WAIT: out_valid is 0, pushes continue until full, and operands of the issued op are not re-presented (the divider latches its own operands).
  - long_done while IDLE: ignored.
- Flush, highest priority:
  - Next cycle: count 0, pointers 0, state IDLE, in_ready 1.
  - A push in the flush cycle is dropped.
  - A pop in the flush cycle still counts in issue_cnt; EXE owns that instruction.
  - Flush coincident with long_done: result is IDLE.
  - Stored data need not be cleared, but out_data reads 0 because count is 0.
- Reset mid-operation: all state is discarded immediately; no partial pop is completed.

Decomposition:
- Shared package id_issue_pkg holds:
  - state typedef {IDLE, LONG_WAIT};
  - function ptr_w(DEPTH) = log2(DEPTH);
  - localparam ENTRY_W = DATA_W+1.
- One sub-module: id_issue_ram, a DEPTH x ENTRY_W register array with synchronous write port and asynchronous read port, asynchronously reset.
- Pointers, count, FSM and statistics live in the top level.

Test Plan:
- Reset then 3 back-to-back pushes (payloads 0x1, 0x2, 0x3) with out_ready=0, DEPTH=2 -> in_ready drops after the 2nd push, 3rd is held upstream, occupancy=2; raise out_ready -> pops 0x1, 0x2, 0x3 in order, issue_cnt=3.
- Continuous push+pop with out_ready=1 for 10 cycles at count=1 -> occupancy stays 1, pointers wrap, outputs in order, issue_cnt=10.
- Push a long op (payload 0xD1V) then normal 0xA -> 0xD1V pops, long_busy=1 and out_valid=0 for 5 cycles; long_done pulse -> 0xA issues the next cycle.
- Flush with count=2 and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0, dropped push is never seen.
- Flush during LONG_WAIT coinciding with long_done -> state IDLE, long_busy=0; a new push issues 1 cycle later.
- Assert rst asynchronously mid-stream with count=1 -> out_valid, occupancy and issue_cnt go to 0 before the next clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared types and helpers for the ID/EXE issue queue.
// Entries carry the decoded payload plus one long-latency flag bit.
package id_issue_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        LONG_WAIT = 1'b1
    } state_e;

    localparam int DEF_DATA_W = 192;
    localparam int ENTRY_W    = DEF_DATA_W + 1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/id_issue_queue_if.sv
// Decode-side and EXE-side valid/ready handshake of the issue queue.
interface id_issue_queue_if #(
    parameter int DATA_W = id_issue_pkg::DEF_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_long;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_long, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_long, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/id_issue_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module id_issue_ram
    import id_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is small and flop-based, so it is reset like any other
    // state; a true SRAM macro would not be, and out_data masking would then
    // be the only thing hiding stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_issue_queue.sv
// Decode-to-EXE issue queue with flush, long-latency interlock and issue count.
// Pointers, occupancy, the long-op FSM and statistics live here; storage is in id_issue_ram.
module id_issue_queue
    import id_issue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    id_issue_queue_if.slave        bus,
    input  logic                   long_done,
    input  logic                   flush,
    output logic [ptr_w(DEPTH):0]  occupancy,
    output logic                   long_busy,
    output logic [CNT_W-1:0]       issue_cnt
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] count_q, count_d;
    logic             full_q;
    logic [CNT_W-1:0] issue_cnt_q;
    logic             push, pop;
    logic             not_empty;
    logic [DATA_W:0]  rd_entry;

    assign not_empty = (count_q != '0);
    assign push      = bus.in_valid & bus.in_ready & ~flush;
    assign pop       = bus.out_valid & bus.out_ready;

    // in_ready comes from a flop; rst only gates it so it reads 0 during reset.
    assign bus.in_ready  = ~full_q & ~rst;
    assign bus.out_valid = not_empty & (state_q == IDLE);
    assign bus.out_data  = not_empty ? rd_entry[DATA_W-1:0] : '0;

    assign occupancy = count_q;
    assign long_busy = (state_q == LONG_WAIT);
    assign issue_cnt = issue_cnt_q;

    id_issue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({bus.in_long, bus.in_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pop && rd_entry[DATA_W]) state_d = LONG_WAIT;
            LONG_WAIT: if (long_done)               state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            full_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= (count_d == FULL);
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A pop in a flush cycle still left for EXE, so it is counted.
            if (pop) issue_cnt_q <= issue_cnt_q + 1'b1;
        end
    end

endmodule
